mac_acc_block: RTL and testbench
================================

// Module: mac_acc_block
// PURPOSE
//  Accumulation stage downstream of the per-lane multiply blocks: consumes the combined partial product C
//  (single/dual/quad packing) over a valid/ready handshake, sums a batch of terms terminated by in_last,
//  and presents the registered result over a second valid/ready handshake. Sits between mul and writeback.
// PARAMETERS
//  MAC_CONF_WIDTH  3                  cfg width; cfg[1:0] uses `MAC_SINGLE/`MAC_DUAL/`MAC_QUAD from mac_const.vh
//  MAC_MIN_WIDTH   8                  base operand width
//  MAC_INT_WIDTH   5*MAC_MIN_WIDTH    width of incoming product C (40)
//  MAC_ACC_WIDTH   MAC_INT_WIDTH+8    accumulator / result width (48)
//  MAC_CNT_WIDTH   8                  beat counter width
// PORTS
//  clk         in   1               clock, all state on rising edge
//  rst_n       in   1               asynchronous, active-low reset
//  en          in   1               stage enable; low freezes all state
//  clr         in   1               synchronous abort/clear
//  cfg         in   MAC_CONF_WIDTH  packing mode, sampled on first beat of a batch
//  in_valid    in   1               C/in_last valid
//  in_ready    out  1               stage can accept a beat
//  C           in   MAC_INT_WIDTH   product from mul block
//  in_last     in   1               final term of batch
//  out_valid   out  1               acc_out valid
//  out_ready   in   1               consumer accepts result
//  acc_out     out  MAC_ACC_WIDTH   accumulated result
//  beat_count  out  MAC_CNT_WIDTH   beats in current/last batch, saturating
//  ovf         out  1               sticky: batch exceeded MAC_ACC_WIDTH
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE; acc, acc_out, beat_count, ovf, out_valid, cfg_q = 0.
//  - FSM IDLE -> ACCUM (beat accepted, !in_last); IDLE/ACCUM -> HOLD (beat accepted with in_last);
//    HOLD -> IDLE (out_valid && out_ready). Single-beat batch goes IDLE -> HOLD directly.
//  - in_ready = en && (state != HOLD). Beat accepted when in_valid && in_ready.
//  - Masking by cfg_q (cfg taken live on IDLE beat): SINGLE uses C[15:0], DUAL C[23:0], QUAD C[39:0];
//    upper bits ignored; zero-extend (unsigned) to MAC_ACC_WIDTH. Reserved cfg: term = 0.
//  - IDLE beat: acc <= term, beat_count <= 1, ovf <= 0. ACCUM beat: acc <= acc + term, beat_count+1
//    (sticks at all-ones), ovf |= carry out of MAC_ACC_WIDTH; sum wraps modulo 2^MAC_ACC_WIDTH.
//  - Latency: out_valid rises the cycle after the in_last beat; acc_out = final sum incl. that beat.
//  - HOLD: acc_out, beat_count, ovf stable until handshake; out_valid drops the cycle after
//    out_valid && out_ready; acc cleared; beat_count/ovf keep last values until next IDLE beat.
//  - en=0: no beat accepted, no output handshake completes, all registers hold.
//  - clr=1 (when en=1): highest priority; next cycle state=IDLE, out_valid=0, acc=0, beat_count=0,
//    ovf=0; any beat presented that cycle is dropped. clr with en=0 is ignored.
//  - cfg changes during ACCUM/HOLD have no effect until next batch.
// CONFIGURATION
//  - MAC_ACC_SATURATE_EN defined: on carry out, acc clamps to all-ones and stays clamped for the rest of
//    the batch; ovf still set. Undefined: wrap-around as above.
// TESTING
//  1. QUAD, C = 0x10, 0x20, 0x30 (last on 3rd), out_ready=1 -> acc_out=0x60, beat_count=3, ovf=0,
//     out_valid high exactly 1 cycle, the cycle after beat 3.
//  2. SINGLE, single beat C=40'h00_0001_FFFF, in_last=1 -> acc_out=0xFFFF; DUAL same C -> 0x01FFFF.
//  3. Backpressure: batch done, out_ready=0 for 5 cycles -> in_ready=0, acc_out stable; out_ready=1
//     -> out_valid falls next cycle, in_ready returns 1.
//  4. QUAD, 257 beats of 40'hFF_FFFF_FFFF -> ovf=1, beat_count=255; acc_out=48'h0FF_FFFF_FEFF
//     (wrap) or 48'hFFFF_FFFF_FFFF with MAC_ACC_SATURATE_EN.
//  5. clr asserted after 2 beats of a batch -> out_valid never rises; next batch C=0x5 last
//     -> acc_out=0x5, beat_count=1.
//  6. rst_n pulsed low mid-batch (async, between edges) -> all outputs 0 immediately; post-reset batch
//     C=0x7 last -> acc_out=0x7.

Source files
------------

// File: rtl/mac_acc_block.sv
// Accumulation stage between mul and writeback: sums packed partial products into batches and hands them on.
// Optional build macro MAC_ACC_SATURATE_EN clamps the accumulator on overflow instead of wrapping.
module mac_acc_block #(
  parameter int MAC_CONF_WIDTH = 3,
  parameter int MAC_MIN_WIDTH  = 8,
  parameter int MAC_INT_WIDTH  = 5 * MAC_MIN_WIDTH,
  parameter int MAC_ACC_WIDTH  = MAC_INT_WIDTH + 8,
  parameter int MAC_CNT_WIDTH  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      clr,
  input  logic [MAC_CONF_WIDTH-1:0] cfg,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [MAC_INT_WIDTH-1:0]  C,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [MAC_ACC_WIDTH-1:0]  acc_out,
  output logic [MAC_CNT_WIDTH-1:0]  beat_count,
  output logic                      ovf
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  // Packing codes match MAC_SINGLE/MAC_DUAL/MAC_QUAD in mac_const.vh; only cfg[1:0] selects the mode.
  localparam logic [MAC_CONF_WIDTH-1:0] MODE_MASK   = MAC_CONF_WIDTH'(3);
  localparam logic [MAC_CONF_WIDTH-1:0] MODE_SINGLE = MAC_CONF_WIDTH'(0);
  localparam logic [MAC_CONF_WIDTH-1:0] MODE_DUAL   = MAC_CONF_WIDTH'(1);
  localparam logic [MAC_CONF_WIDTH-1:0] MODE_QUAD   = MAC_CONF_WIDTH'(2);

  localparam logic [MAC_ACC_WIDTH-1:0] ACC_ONE     = MAC_ACC_WIDTH'(1);
  localparam logic [MAC_ACC_WIDTH-1:0] MASK_SINGLE = (ACC_ONE << (2 * MAC_MIN_WIDTH)) - ACC_ONE;
  localparam logic [MAC_ACC_WIDTH-1:0] MASK_DUAL   = (ACC_ONE << (3 * MAC_MIN_WIDTH)) - ACC_ONE;
  localparam logic [MAC_ACC_WIDTH-1:0] MASK_QUAD   = (ACC_ONE << MAC_INT_WIDTH) - ACC_ONE;
  localparam logic [MAC_CNT_WIDTH-1:0] CNT_ONE     = MAC_CNT_WIDTH'(1);

  state_t                    state;
  logic [MAC_ACC_WIDTH-1:0]  acc;
  logic [MAC_CONF_WIDTH-1:0] cfg_q;

  logic [MAC_CONF_WIDTH-1:0] mode;
  logic [MAC_ACC_WIDTH-1:0]  c_ext;
  logic [MAC_ACC_WIDTH-1:0]  term;
  logic [MAC_ACC_WIDTH-1:0]  base;
  logic [MAC_ACC_WIDTH:0]    sum;
  logic                      carry;
  logic [MAC_ACC_WIDTH-1:0]  acc_next;
  logic [MAC_CNT_WIDTH-1:0]  cnt_next;
  logic                      ovf_next;
  logic                      first_beat;

  assign in_ready = en && (state != HOLD);

  // The first beat of a batch uses the live cfg and starts from zero; later beats use the latched mode.
  always_comb begin
    first_beat = (state == IDLE);
    mode       = first_beat ? cfg : cfg_q;
    c_ext      = {{(MAC_ACC_WIDTH - MAC_INT_WIDTH){1'b0}}, C};
    term       = '0;
    case (mode & MODE_MASK)
      MODE_SINGLE: term = c_ext & MASK_SINGLE;
      MODE_DUAL:   term = c_ext & MASK_DUAL;
      MODE_QUAD:   term = c_ext & MASK_QUAD;
      default:     term = '0;
    endcase
    base  = first_beat ? '0 : acc;
    sum   = {1'b0, base} + {1'b0, term};
    carry = sum[MAC_ACC_WIDTH];
`ifdef MAC_ACC_SATURATE_EN
    acc_next = carry ? '1 : sum[MAC_ACC_WIDTH-1:0];
`else
    acc_next = sum[MAC_ACC_WIDTH-1:0];
`endif
    if (first_beat)
      cnt_next = CNT_ONE;
    else if (beat_count == '1)
      cnt_next = beat_count;
    else
      cnt_next = beat_count + CNT_ONE;
    ovf_next = first_beat ? 1'b0 : (ovf | carry);
  end

  // Batch FSM; clr wins over any beat or output handshake, and en low freezes everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      acc        <= '0;
      acc_out    <= '0;
      beat_count <= '0;
      ovf        <= 1'b0;
      out_valid  <= 1'b0;
      cfg_q      <= '0;
    end else if (en) begin
      if (clr) begin
        state      <= IDLE;
        acc        <= '0;
        beat_count <= '0;
        ovf        <= 1'b0;
        out_valid  <= 1'b0;
      end else begin
        case (state)
          IDLE, ACCUM: begin
            if (in_valid) begin
              acc        <= acc_next;
              beat_count <= cnt_next;
              ovf        <= ovf_next;
              if (first_beat)
                cfg_q <= cfg;
              if (in_last) begin
                acc_out   <= acc_next;
                out_valid <= 1'b1;
                state     <= HOLD;
              end else begin
                state <= ACCUM;
              end
            end
          end
          HOLD: begin
            if (out_ready) begin
              out_valid <= 1'b0;
              acc       <= '0;
              state     <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mac_acc_block.sv
// Directed self-checking bench for mac_acc_block; expected values are hand-computed per vector.
module tb_mac_acc_block;

  localparam logic [2:0] SINGLE = 3'd0;
  localparam logic [2:0] DUAL   = 3'd1;
  localparam logic [2:0] QUAD   = 3'd2;
  localparam logic [2:0] RSVD   = 3'd3;

`ifdef MAC_ACC_SATURATE_EN
  localparam logic [47:0] BIG_SUM = 48'hFFFF_FFFF_FFFF;
`else
  localparam logic [47:0] BIG_SUM = 48'h00FF_FFFF_FEFF;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;
  logic        clr = 1'b0;
  logic [2:0]  cfg = 3'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [39:0] C = 40'd0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [47:0] acc_out;
  logic [7:0]  beat_count;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  mac_acc_block dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .clr        (clr),
    .cfg        (cfg),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .C          (C),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .acc_out    (acc_out),
    .beat_count (beat_count),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Presents one beat for a single clock edge, leaving time at edge+1.
  task automatic applyStimulus(input logic [39:0] c, input logic last, input logic [2:0] mode);
    in_valid = 1'b1;
    C        = c;
    in_last  = last;
    cfg      = mode;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #12;
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_acc_out", 64'(acc_out), 64'd0);
    checkOutput("rst_beat_count", 64'(beat_count), 64'd0);
    checkOutput("rst_ovf", 64'(ovf), 64'd0);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    #11 rst_n = 1'b1;
    nextCycle();

    // Three-beat quad batch
    applyStimulus(40'h10, 1'b0, QUAD);
    applyStimulus(40'h20, 1'b0, QUAD);
    checkOutput("t1_no_early_valid", 64'(out_valid), 64'd0);
    applyStimulus(40'h30, 1'b1, QUAD);
    checkOutput("t1_valid", 64'(out_valid), 64'd1);
    checkOutput("t1_acc_out", 64'(acc_out), 64'h60);
    checkOutput("t1_beat_count", 64'(beat_count), 64'd3);
    checkOutput("t1_ovf", 64'(ovf), 64'd0);
    checkOutput("t1_in_ready_hold", 64'(in_ready), 64'd0);
    nextCycle();
    checkOutput("t1_valid_drop", 64'(out_valid), 64'd0);
    checkOutput("t1_in_ready_back", 64'(in_ready), 64'd1);
    checkOutput("t1_count_kept", 64'(beat_count), 64'd3);

    // Packing masks
    applyStimulus(40'h00_0001_FFFF, 1'b1, SINGLE);
    checkOutput("t2_single", 64'(acc_out), 64'hFFFF);
    checkOutput("t2_single_cnt", 64'(beat_count), 64'd1);
    nextCycle();
    applyStimulus(40'h00_0001_FFFF, 1'b1, DUAL);
    checkOutput("t2_dual", 64'(acc_out), 64'h1FFFF);
    nextCycle();
    applyStimulus(40'h55, 1'b1, RSVD);
    checkOutput("t2_reserved", 64'(acc_out), 64'd0);
    nextCycle();
    applyStimulus(40'h12_3456_789A, 1'b0, SINGLE);
    applyStimulus(40'h00_0001_0001, 1'b1, QUAD);
    checkOutput("t2_cfg_latched", 64'(acc_out), 64'h789B);
    checkOutput("t2_cfg_cnt", 64'(beat_count), 64'd2);
    nextCycle();

    // Backpressure with a beat waiting that must not be taken
    out_ready = 1'b0;
    applyStimulus(40'h3, 1'b1, QUAD);
    in_valid = 1'b1;
    C        = 40'h100;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      nextCycle();
      checkOutput("t3_in_ready", 64'(in_ready), 64'd0);
      checkOutput("t3_valid_held", 64'(out_valid), 64'd1);
      checkOutput("t3_acc_stable", 64'(acc_out), 64'h3);
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    nextCycle();
    checkOutput("t3_valid_drop", 64'(out_valid), 64'd0);
    checkOutput("t3_in_ready_back", 64'(in_ready), 64'd1);

    // Enable low: no beat accepted, no handshake completes
    en       = 1'b0;
    in_valid = 1'b1;
    C        = 40'h9;
    in_last  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      nextCycle();
      checkOutput("en_in_ready", 64'(in_ready), 64'd0);
      checkOutput("en_no_accept", 64'(out_valid), 64'd0);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    en       = 1'b1;
    checkOutput("en_acc_kept", 64'(acc_out), 64'h3);
    applyStimulus(40'h4, 1'b1, QUAD);
    en = 1'b0;
    nextCycle();
    checkOutput("en_hold_valid", 64'(out_valid), 64'd1);
    en = 1'b1;
    nextCycle();
    checkOutput("en_hold_release", 64'(out_valid), 64'd0);

    // 257 all-ones quad beats: counter saturates, carry on the last beat
    for (int i = 0; i < 256; i++)
      applyStimulus(40'hFF_FFFF_FFFF, 1'b0, QUAD);
    checkOutput("t4_ovf_before", 64'(ovf), 64'd0);
    checkOutput("t4_cnt_sat", 64'(beat_count), 64'd255);
    applyStimulus(40'hFF_FFFF_FFFF, 1'b1, QUAD);
    checkOutput("t4_acc_out", 64'(acc_out), 64'(BIG_SUM));
    checkOutput("t4_ovf", 64'(ovf), 64'd1);
    checkOutput("t4_cnt", 64'(beat_count), 64'd255);
    nextCycle();
    checkOutput("t4_ovf_kept", 64'(ovf), 64'd1);

    // Clear mid-batch, with a last beat presented in the same cycle
    applyStimulus(40'h11, 1'b0, QUAD);
    applyStimulus(40'h22, 1'b0, QUAD);
    clr      = 1'b1;
    in_valid = 1'b1;
    C        = 40'h44;
    in_last  = 1'b1;
    nextCycle();
    clr      = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    checkOutput("t5_no_valid", 64'(out_valid), 64'd0);
    checkOutput("t5_cnt_clr", 64'(beat_count), 64'd0);
    checkOutput("t5_ovf_clr", 64'(ovf), 64'd0);
    checkOutput("t5_in_ready", 64'(in_ready), 64'd1);
    nextCycle();
    checkOutput("t5_still_no_valid", 64'(out_valid), 64'd0);
    applyStimulus(40'h5, 1'b1, QUAD);
    checkOutput("t5_acc_out", 64'(acc_out), 64'h5);
    checkOutput("t5_cnt", 64'(beat_count), 64'd1);
    nextCycle();

    // Asynchronous reset between edges mid-batch
    applyStimulus(40'h100, 1'b0, QUAD);
    applyStimulus(40'h200, 1'b0, QUAD);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("t6_valid", 64'(out_valid), 64'd0);
    checkOutput("t6_acc_out", 64'(acc_out), 64'd0);
    checkOutput("t6_cnt", 64'(beat_count), 64'd0);
    checkOutput("t6_ovf", 64'(ovf), 64'd0);
    #2 rst_n = 1'b1;
    nextCycle();
    applyStimulus(40'h7, 1'b1, QUAD);
    checkOutput("t6_post_acc", 64'(acc_out), 64'h7);
    checkOutput("t6_post_cnt", 64'(beat_count), 64'd1);
    nextCycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
